uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
Oversampling UART receiver with an output FIFO. It is the receive-direction counterpart to the team's transmitter and sits beside it under the uart top.
- Recovers 8N1 or 8E1 frames from the asynchronous rx line, clocked by the 16x sample tick from bitrate_converter.
- Queues each byte, with its error flags, behind a valid/ready interface.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; even, at least 8.
PARITY_EN, 1, 1 = even parity bit expected between data and stop; 0 = no parity bit.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock, rising edge.
resetN  input  1  synchronous active-low reset.
rx_en  input  1  one-clk pulse per sample tick (OVERSAMPLE per bit).
rx  input  1  asynchronous serial line; idle high.
data_out  output  8  FIFO head byte; valid only while valid=1.
parity_err  output  1  FIFO head parity-mismatch flag.
frame_err  output  1  FIFO head stop-bit-low flag.
valid  output  1  FIFO not empty.
ready  input  1  consumer accepts the head entry when valid&ready.
overrun  output  1  sticky: a frame was dropped because the FIFO was full.
ovr_clr  input  1  clears overrun.
busy  output  1  receive FSM not in IDLE.

Behaviour:
- Reset (resetN=0 at a clk edge):
  - rx synchronizer to 1, FSM to IDLE, tick counter and bit counter to 0.
  - FIFO emptied; data_out, parity_err, frame_err, valid, overrun, busy all 0.
  - A reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchronizer; all FSM sampling uses the synchronized value rxs.
- FSM advances only on cycles where rx_en=1. tcnt counts ticks 0..OVERSAMPLE-1 within a state.
- IDLE: if rxs=0 on a tick, go to START with tcnt=0.
- START: at tcnt=OVERSAMPLE/2-1 (mid start bit):
  - rxs=0: go to DATA, tcnt=0, bitcnt=0.
  - rxs=1: false start; return to IDLE with no push.
- DATA: at tcnt=OVERSAMPLE-1, sample rxs and shift it in LSB first; bitcnt++. After bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: sample at tcnt=OVERSAMPLE-1. perr = sampled bit XOR (XOR-reduce of the data byte). Even parity is the rule.
- STOP: sample at tcnt=OVERSAMPLE-1.
  - ferr = ~rxs. perr is 0 when PARITY_EN=0.
  - Push {ferr, perr, byte} on the same clk and return to IDLE. A following start bit is therefore detected from the next tick.
  - Frames with errors are still pushed; the consumer decides what to do with them.
- Latency: the pushed entry appears on data_out/valid 1 clk after the stop-bit sample (registered FIFO write). No extra synchronizer latency is added at the output side.
- FIFO: head-of-queue interface with rd_ptr/wr_ptr of width log2(DEPTH) plus one wrap bit.
  - full when the pointers are equal and the wrap bits differ; empty when pointers and wrap bits are both equal.
  - Pop on valid&ready. ready while empty is ignored.
- Push while full with no pop: frame dropped, overrun set to 1. overrun stays 1 until ovr_clr=1.
- If ovr_clr and a new overrun event occur in the same clk, overrun = 1 (set wins).
- Push and pop in the same clk while full: both happen; the count stays DEPTH and overrun is unchanged.
- Push and pop in the same clk while empty: not possible, since valid=0.
- busy = (state != IDLE).

Decomposition:
- Shared uart package holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - FRAME_BITS=8;
  - the FIFO entry layout (bit 9 frame_err, bit 8 parity_err, bits 7:0 data);
  - the even-parity function, which the transmitter also uses.
- One sub-module is natural: uart_rx_fifo (parameter DEPTH, WIDTH=10) containing the pointer/full/empty logic. The FSM and synchronizer stay in the top.

Test Plan:
1. Defaults; send 0xA5 with parity bit 0, stop bit 1, 16 ticks per bit -> valid=1 with data_out=0xA5, parity_err=0, frame_err=0; ready=1 pops it and valid returns to 0.
2. Send 0x01 with parity bit 0 (wrong; correct is 1) -> entry 0x01 with parity_err=1, frame_err=0.
3. Send 0x3C with stop bit driven 0 -> entry 0x3C with frame_err=1. The next frame, 0x55, received back-to-back, is also correct.
4. rx low pulse of 4 ticks in IDLE -> FSM returns to IDLE; no push; busy=0 afterwards.
5. ready=0; send 5 frames 0x10..0x14 -> first 4 held in order; overrun=1 after frame 5. Draining yields 0x10..0x13. ovr_clr=1 then clears overrun.
6. resetN=0 asserted for 1 clk during bit 4 of 0xFF -> valid=0, busy=0, overrun=0; a subsequent 0x42 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width, FIFO entry layout
// and the even-parity helper used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int FRAME_BITS = 8;

   // FIFO entry: {frame_err, parity_err, data}
   localparam int ENTRY_W    = FRAME_BITS + 2;
   localparam int ENTRY_FERR = FRAME_BITS + 1;
   localparam int ENTRY_PERR = FRAME_BITS;

   // Parity bit value that makes the total count of ones even.
   function automatic logic even_parity(input logic [FRAME_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: registered write, head-of-queue read, wrap-bit pointers.
// A push while full is accepted only when a pop happens on the same clk.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Head is forced to zero while empty so stale entries never leak out.
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1/8E1 UART receiver feeding a small valid/ready FIFO,
// with a sticky overrun flag for frames dropped while the FIFO is full.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs=0 on a tick
// START  | counting to mid start bit to confirm it
// DATA   | sampling 8 data bits LSB first at end of each bit period
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, pushing the entry
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 1,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       rx_en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       parity_err,
   output logic       frame_err,
   output logic       valid,
   input  logic       ready,
   output logic       overrun,
   input  logic       ovr_clr,
   output logic       busy
);

   localparam int            TW     = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]    B_LAST = 3'(FRAME_BITS - 1);

   rx_state_t             state, state_n;
   logic [TW-1:0]         tcnt, tcnt_n;
   logic [2:0]            bitcnt, bitcnt_n;
   logic [FRAME_BITS-1:0] shreg, shreg_n;
   logic                  perr_q, perr_n;
   logic                  rx_meta, rxs;
   logic                  push;
   logic [ENTRY_W-1:0]    push_data;
   logic [ENTRY_W-1:0]    head;
   logic                  empty, full;
   logic                  ovr_set;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         state   <= IDLE;
         tcnt    <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         perr_q  <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         state   <= state_n;
         tcnt    <= tcnt_n;
         bitcnt  <= bitcnt_n;
         shreg   <= shreg_n;
         perr_q  <= perr_n;
      end
   end

   always_comb begin
      state_n   = state;
      tcnt_n    = tcnt;
      bitcnt_n  = bitcnt;
      shreg_n   = shreg;
      perr_n    = perr_q;
      push      = 1'b0;
      push_data = {~rxs, perr_q, shreg};
      if (rx_en) begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state_n = START;
                  tcnt_n  = '0;
               end
            end
            START: begin
               if (tcnt == T_MID) begin
                  tcnt_n   = '0;
                  bitcnt_n = '0;
                  perr_n   = 1'b0;
                  state_n  = rxs ? IDLE : DATA;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            DATA: begin
               if (tcnt == T_LAST) begin
                  tcnt_n   = '0;
                  shreg_n  = {rxs, shreg[FRAME_BITS-1:1]};
                  bitcnt_n = bitcnt + 3'd1;
                  if (bitcnt == B_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            PARITY: begin
               if (tcnt == T_LAST) begin
                  tcnt_n  = '0;
                  perr_n  = rxs ^ even_parity(shreg);
                  state_n = STOP;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            STOP: begin
               if (tcnt == T_LAST) begin
                  tcnt_n  = '0;
                  push    = 1'b1;
                  state_n = IDLE;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               tcnt_n  = '0;
            end
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk    (clk),
      .resetN (resetN),
      .push   (push),
      .wdata  (push_data),
      .pop    (ready),
      .rdata  (head),
      .empty  (empty),
      .full   (full)
   );

   assign valid      = !empty;
   assign data_out   = head[FRAME_BITS-1:0];
   assign parity_err = head[ENTRY_PERR];
   assign frame_err  = head[ENTRY_FERR];
   assign busy       = (state != IDLE);

   // A same-clk pop frees a slot, so only push-while-full-without-pop drops.
   assign ovr_set = push && full && !(ready && valid);

   always_ff @(posedge clk) begin
      if (!resetN)      overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
   end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames are bit-banged on rx against a
// 1-in-4 clk sample tick; DUT outputs are checked on the falling clk edge.
module tb_uart_rx_buffered;

   logic       clk = 1'b0;
   logic       resetN;
   logic       rx_en;
   logic       rx;
   logic [7:0] data_out;
   logic       parity_err;
   logic       frame_err;
   logic       valid;
   logic       ready;
   logic       overrun;
   logic       ovr_clr;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_buffered dut (
      .clk        (clk),
      .resetN     (resetN),
      .rx_en      (rx_en),
      .rx         (rx),
      .data_out   (data_out),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .valid      (valid),
      .ready      (ready),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      rx_en = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         rx_en = 1'b1;
         @(negedge clk);
         rx_en = 1'b0;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!rx_en) @(posedge clk);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      rx = b;
      wait_ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((^d) ^ bad_par);
      send_bit(stop_bit);
      @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic check_head(input string tag, input logic [7:0] d, input logic pe, input logic fe);
      @(negedge clk);
      check({tag, "_valid"}, valid, 1);
      check({tag, "_data"}, data_out, d);
      check({tag, "_perr"}, parity_err, pe);
      check({tag, "_ferr"}, frame_err, fe);
   endtask

   task automatic pop_one();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      resetN  = 1'b0;
      rx      = 1'b1;
      ready   = 1'b0;
      ovr_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data", data_out, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
      resetN = 1'b1;
      wait_ticks(4);

      // 1: clean frame, then pop
      send_frame(8'hA5, 1'b0, 1'b1);
      check_head("t1", 8'hA5, 0, 0);
      check("t1_busy", busy, 0);
      pop_one();
      check("t1_empty", valid, 0);

      // 2: wrong parity bit
      send_frame(8'h01, 1'b1, 1'b1);
      check_head("t2", 8'h01, 1, 0);
      pop_one();

      // 3: stop bit low, then a back-to-back frame
      send_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b1);
      check_head("t3a", 8'h3C, 0, 1);
      pop_one();
      check_head("t3b", 8'h55, 0, 0);
      pop_one();
      check("t3_empty", valid, 0);
      wait_ticks(4);

      // 4: short low glitch is a false start
      @(negedge clk);
      rx = 1'b0;
      wait_ticks(4);
      @(negedge clk);
      rx = 1'b1;
      check("t4_busy_mid", busy, 1);
      wait_ticks(12);
      @(negedge clk);
      check("t4_busy", busy, 0);
      check("t4_valid", valid, 0);

      // 5: overflow the FIFO
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
      @(negedge clk);
      check("t5_ovr_before", overrun, 0);
      send_frame(8'h14, 1'b0, 1'b1);
      @(negedge clk);
      check("t5_ovr_set", overrun, 1);
      for (int i = 0; i < 4; i++) begin
         check_head("t5_drain", 8'h10 + 8'(i), 0, 0);
         pop_one();
      end
      check("t5_empty", valid, 0);
      check("t5_ovr_sticky", overrun, 1);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("t5_ovr_clr", overrun, 0);

      // 6: reset during bit 4 of 0xFF; leave one entry queued first
      send_frame(8'h42, 1'b0, 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_ticks(8);
      @(negedge clk);
      check("t6_busy_pre", busy, 1);
      check("t6_valid_pre", valid, 1);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      check("t6_valid", valid, 0);
      check("t6_busy", busy, 0);
      check("t6_overrun", overrun, 0);
      wait_ticks(24);
      send_frame(8'h42, 1'b0, 1'b1);
      check_head("t6", 8'h42, 0, 0);
      pop_one();
      check("t6_empty", valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
